fib_arbiter: RTL and testbench
==============================

# fib_arbiter

Round-robin arbiter and sequencer that shares one Fibonacci engine (start/i/ready/done_tick/f handshake) among N requesters. It sits between the requesting blocks and the engine. It latches one requester's index, launches the engine, waits for completion, and returns the result to the winner with a one-cycle done pulse. It also keeps a count of completed jobs.

## Interface
- N_REQ, 4, number of requesters (2..8)
- IW, 5, index width
- FW, 20, result width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester level request
- idx  in  N_REQ*IW  packed indices; requester k uses bits [k*IW +: IW]
- grant  out  N_REQ  one-hot; current owner of the engine
- done  out  N_REQ  one-cycle pulse to the owner when its result is valid
- f  out  FW  result of the last completed job; holds until the next delivery
- busy  out  1  high in every state except IDLE
- job_count  out  16  completed-job counter; wraps at 65535 -> 0
- eng_start  out  1  start strobe to the engine
- eng_i  out  IW  index to the engine
- eng_ready  in  1  engine idle indicator
- eng_done_tick  in  1  engine completion pulse; eng_f is valid in the same cycle
- eng_f  in  FW  engine result

## Operation
- Reset values: state IDLE; grant=0, done=0, f=0, busy=0, job_count=0, eng_start=0, eng_i=0, rr_ptr=0.
- All outputs come from registers or decode directly from the state register. There are no combinational paths from req to outputs.
- State machine:
  - **IDLE**: if |req and eng_ready, pick winner w, set grant to one-hot w, latch eng_i=idx[w], go to LAUNCH. Otherwise stay in IDLE. If eng_ready is low, wait regardless of req.
  - **LAUNCH**: eng_start=1 for exactly this cycle. Go to WAIT.
  - **WAIT**: on eng_done_tick=1, capture f<=eng_f and go to DELIVER. Otherwise stay in WAIT; there is no timeout.
  - **DELIVER**: done[w]=1 for one cycle. job_count increments. Next cycle: IDLE, grant=0, rr_ptr=(w+1) mod N_REQ.
- Winner selection (RR mode): first asserted req scanning from rr_ptr upward, with wrap-around.
- Requester rules:
  - Hold req and idx until done is seen, then drop req within one cycle to avoid being re-served.
  - idx is sampled only in the IDLE grant cycle. Later changes to idx have no effect on the job in flight.
  - If req drops mid-job, the job still completes. done and f are delivered and job_count increments.
- Simultaneous events:
  - New requests arriving during LAUNCH/WAIT/DELIVER wait in IDLE for arbitration.
  - A requester that still holds req in DELIVER is eligible again, but only after all other pending requesters have been served (RR).
- Arithmetic: f passes through unmodified modulo 2^FW. The arbiter performs no overflow detection.
- Reset mid-job: returns everything to reset values immediately. The engine's own reset handles the engine side; no done pulse is produced for the aborted job.

## Timing
- Grant latency: req sampled high at edge T in IDLE with eng_ready=1 gives grant and LAUNCH in cycle T+1 and eng_start in cycle T+1.
- Completion: eng_done_tick high in cycle D gives done[w] and the new f in cycle D+1. grant clears in cycle D+2.
- Minimum spacing between jobs is one IDLE cycle. Back-to-back turnaround from done to the next eng_start is 2 cycles.
- Engine latency is not assumed. The arbiter waits on eng_done_tick only.

## Configuration
- FIB_ARB_RR_EN defined: round-robin arbitration as above. rr_ptr advances after every delivery.
- FIB_ARB_RR_EN undefined: fixed priority, where the lowest asserted index wins. rr_ptr is not implemented. Starvation of higher indices is accepted.

## Test plan
- Reset: assert reset for 2 cycles mid-WAIT -> all outputs 0, state IDLE, no done pulse; then a new req[0] with idx=10 is served normally and f=55.
- Single job: req[2]=1, idx=20 -> grant=4'b0100, one eng_start pulse, done=4'b0100 for 1 cycle, f=6765, job_count=1.
- Boundary indices: sequential jobs with idx 0, 1, 30 -> f=0, 1, 832040 respectively.
- RR fairness (RR_EN): all four req held high with idx=k+3 -> grants in order 0,1,2,3,0; f=2,3,5,8,2.
- Fixed priority (no RR_EN): req[0] and req[3] held high -> req[0] is served repeatedly and grant never equals 4'b1000.
- Handshake edges:
  - eng_ready held low for 5 cycles with req pending -> no grant until eng_ready rises.
  - req drop mid-WAIT -> done still pulses once.
  - idx changed after grant -> result uses the latched idx.

Source files
------------

// File: rtl/fib_arbiter.sv
// Shares one Fibonacci engine among N_REQ requesters: arbitrate, launch, wait, deliver.
// Define FIB_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module fib_arbiter #(
   parameter int N_REQ = 4,
   parameter int IW    = 5,
   parameter int FW    = 20
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_REQ-1:0]      req,
   input  logic [N_REQ*IW-1:0]   idx,
   output logic [N_REQ-1:0]      grant,
   output logic [N_REQ-1:0]      done,
   output logic [FW-1:0]         f,
   output logic                  busy,
   output logic [15:0]           job_count,
   output logic                  eng_start,
   output logic [IW-1:0]         eng_i,
   input  logic                  eng_ready,
   input  logic                  eng_done_tick,
   input  logic [FW-1:0]         eng_f
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_LAUNCH  = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_DELIVER = 2'd3;

`ifdef FIB_ARB_RR_EN
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PW-1:0]      r_rr_ptr;
   logic [PW-1:0]      r_owner;
   logic [PW-1:0]      w_win;
`endif

   logic [1:0]         r_state;
   logic [N_REQ-1:0]   r_grant;
   logic [N_REQ-1:0]   r_done;
   logic [FW-1:0]      r_f;
   logic [15:0]        r_job_count;
   logic [IW-1:0]      r_eng_i;

   logic               w_any;
   logic [N_REQ-1:0]   w_win_oh;
   logic [IW-1:0]      w_win_idx;

   // Winner search: scan starts at rr_ptr (round-robin) or at 0 (fixed priority).
   always_comb begin
      int  j;
      logic found;
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      j         = 0;
      found     = 1'b0;
      w_any     = |req;
      w_win_oh  = '0;
      w_win_idx = '0;
`ifdef FIB_ARB_RR_EN
      w_win     = '0;
`endif
      for (int k = 0; k < N_REQ; k++) begin
`ifdef FIB_ARB_RR_EN
         j = (int'(r_rr_ptr) + k) % N_REQ;
`else
         j = k;
`endif
         if (!found && req[j]) begin
            found       = 1'b1;
            w_win_oh[j] = 1'b1;
            w_win_idx   = idx[j*IW +: IW];
`ifdef FIB_ARB_RR_EN
            w_win       = PW'(j);
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (reset) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_done      <= '0;
         r_f         <= '0;
         r_job_count <= '0;
         r_eng_i     <= '0;
`ifdef FIB_ARB_RR_EN
         r_rr_ptr    <= '0;
         r_owner     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any && eng_ready) begin
                  r_grant <= w_win_oh;
                  r_eng_i <= w_win_idx;
`ifdef FIB_ARB_RR_EN
                  r_owner <= w_win;
`endif
                  r_state <= S_LAUNCH;
               end
            end
            S_LAUNCH: r_state <= S_WAIT;
            S_WAIT: begin
               // The job completes even if the owner has since dropped req.
               if (eng_done_tick) begin
                  r_f         <= eng_f;
                  r_done      <= r_grant;
                  r_job_count <= r_job_count + 16'd1;
                  r_state     <= S_DELIVER;
               end
            end
            S_DELIVER: begin
               r_done  <= '0;
               r_grant <= '0;
`ifdef FIB_ARB_RR_EN
               r_rr_ptr <= (r_owner == PW'(N_REQ - 1)) ? '0 : r_owner + PW'(1);
`endif
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign grant     = r_grant;
   assign done      = r_done;
   assign f         = r_f;
   assign job_count = r_job_count;
   assign eng_i     = r_eng_i;
   assign busy      = (r_state != S_IDLE);
   assign eng_start = (r_state == S_LAUNCH);

endmodule

// File: tb/tb_fib_arbiter.sv
// Scoreboard bench for fib_arbiter with a behavioural engine; honours FIB_ARB_RR_EN like the design.
module tb_fib_arbiter;

   localparam int N_REQ = 4;
   localparam int IW    = 5;
   localparam int FW    = 20;

   typedef struct {
      logic [N_REQ-1:0] oh;
      logic [FW-1:0]    f;
   } exp_t;

   logic                clk = 1'b0;
   logic                reset;
   logic [N_REQ-1:0]    req;
   logic [N_REQ*IW-1:0] idx;
   logic [N_REQ-1:0]    grant;
   logic [N_REQ-1:0]    done;
   logic [FW-1:0]       f;
   logic                busy;
   logic [15:0]         job_count;
   logic                eng_start;
   logic [IW-1:0]       eng_i;
   logic                eng_ready;
   logic                eng_done_tick;
   logic [FW-1:0]       eng_f;
   logic                eng_hold;

   int   n_checks  = 0;
   int   n_errors  = 0;
   int   n_starts  = 0;
   int   exp_starts = 0;
   exp_t sb[$];

   // Requester agents: each owns a list of job indices served in order.
   int   job_idx[N_REQ][4];
   int   job_n[N_REQ];
   int   job_pos[N_REQ];
   bit   a_gseen[N_REQ];
   bit   drop_early;
   int   model_ptr;

   always #5 clk = ~clk;

   fib_arbiter #(.N_REQ(N_REQ), .IW(IW), .FW(FW)) dut (
      .clk(clk), .reset(reset), .req(req), .idx(idx), .grant(grant), .done(done),
      .f(f), .busy(busy), .job_count(job_count), .eng_start(eng_start), .eng_i(eng_i),
      .eng_ready(eng_ready), .eng_done_tick(eng_done_tick), .eng_f(eng_f)
   );

   function automatic logic [FW-1:0] fib(input int n);
      logic [FW-1:0] a, b, t;
      a = '0;
      b = FW'(1);
      for (int i = 0; i < n; i++) begin
         t = a + b;
         a = b;
         b = t;
      end
      return a;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Engine model: random latency, result valid only with the done tick, junk otherwise.
   logic             e_busy, e_tick;
   int               e_lat;
   logic [IW-1:0]    e_n;
   logic [FW-1:0]    e_res, e_junk;

   always @(posedge clk) begin
      e_junk <= FW'($urandom);
      if (reset) begin
         e_busy <= 1'b0;
         e_tick <= 1'b0;
         e_lat  <= 0;
         e_n    <= '0;
         e_res  <= '0;
      end else begin
         e_tick <= 1'b0;
         if (!e_busy && eng_start) begin
            e_busy <= 1'b1;
            e_n    <= eng_i;
            e_lat  <= int'($urandom_range(1, 6));
         end else if (e_busy) begin
            if (e_lat <= 1) begin
               e_busy <= 1'b0;
               e_tick <= 1'b1;
               e_res  <= fib(int'(e_n));
            end else begin
               e_lat <= e_lat - 1;
            end
         end
      end
   end

   assign eng_done_tick = e_tick;
   assign eng_f         = e_tick ? e_res : e_junk;
   assign eng_ready     = !e_busy && !eng_hold;

   // Monitor: pops an expectation on every done pulse; checks f holds between deliveries.
   logic [15:0]   m_count;
   logic [FW-1:0] m_last_f;
   bit            m_prev_done, m_prev_start;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         m_count      = '0;
         m_last_f     = '0;
         m_prev_done  = 1'b0;
         m_prev_start = 1'b0;
      end else begin
         if (m_prev_done) begin
            check("done_width", 32'(done), 32'd0);
            check("grant_clear", 32'(grant), 32'd0);
            check("busy_clear", 32'(busy), 32'd0);
         end
         if (done != '0) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 32'(done), 32'd0);
               m_last_f = f;
            end else begin
               e = sb.pop_front();
               check("done_owner", 32'(done), 32'(e.oh));
               check("grant_owner", 32'(grant), 32'(e.oh));
               check("result_f", 32'(f), 32'(e.f));
               check("job_count", 32'(job_count), 32'(m_count + 16'd1));
               m_count  = m_count + 16'd1;
               m_last_f = e.f;
            end
         end else begin
            check("f_hold", 32'(f), 32'(m_last_f));
         end
         if (eng_start) begin
            check("start_width", 32'(m_prev_start), 32'd0);
            check("start_ready", 32'(eng_ready), 32'd1);
            n_starts++;
         end
         m_prev_done  = (done != '0);
         m_prev_start = eng_start;
      end
   end

   task automatic agent_step();
      for (int k = 0; k < N_REQ; k++) begin
         if (grant[k] && !a_gseen[k]) begin
            a_gseen[k] = 1'b1;
            job_pos[k]++;
            if (job_pos[k] < job_n[k]) begin
               idx[k*IW +: IW] = IW'(job_idx[k][job_pos[k]]);
            end else begin
               idx[k*IW +: IW] = IW'($urandom);
               if (drop_early) req[k] = 1'b0;
            end
         end
         if (!grant[k]) a_gseen[k] = 1'b0;
         if (done[k] && job_pos[k] >= job_n[k]) req[k] = 1'b0;
      end
   endtask

   // Called right after a negedge; holds reset for cyc cycles and checks reset values.
   task automatic do_reset(input int cyc);
      reset    = 1'b1;
      req      = '0;
      eng_hold = 1'b0;
      repeat (cyc) @(negedge clk);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_f", 32'(f), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_job_count", 32'(job_count), 32'd0);
      check("rst_eng_start", 32'(eng_start), 32'd0);
      check("rst_eng_i", 32'(eng_i), 32'd0);
      sb.delete();
      model_ptr = 0;
      reset     = 1'b0;
      @(negedge clk);
   endtask

   // Predicts the service order from the pending job lists, then drives the agents.
   task automatic run_batch(input bit drop, input int hold);
      int               rem[N_REQ];
      int               used[N_REQ];
      int               total;
      int               pick;
      logic [N_REQ-1:0] first_oh;
      exp_t             e;
      total    = 0;
      first_oh = '0;
      for (int k = 0; k < N_REQ; k++) begin
         rem[k]  = job_n[k];
         used[k] = 0;
         total  += job_n[k];
      end
      for (int s = 0; s < total; s++) begin
         pick = -1;
         for (int t = 0; t < N_REQ; t++) begin
`ifdef FIB_ARB_RR_EN
            int c = (model_ptr + t) % N_REQ;
`else
            int c = t;
`endif
            if (pick < 0 && rem[c] > 0) pick = c;
         end
         e.oh       = '0;
         e.oh[pick] = 1'b1;
         e.f        = fib(job_idx[pick][used[pick]]);
         if (s == 0) first_oh = e.oh;
         sb.push_back(e);
         used[pick]++;
         rem[pick]--;
`ifdef FIB_ARB_RR_EN
         model_ptr = (pick + 1) % N_REQ;
`endif
      end
      exp_starts += total;

      drop_early = drop;
      eng_hold   = (hold > 0);
      for (int k = 0; k < N_REQ; k++) begin
         job_pos[k] = 0;
         a_gseen[k] = 1'b0;
         if (job_n[k] > 0) begin
            idx[k*IW +: IW] = IW'(job_idx[k][0]);
            req[k]          = 1'b1;
         end
      end
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("ready_low_grant", 32'(grant), 32'd0);
         check("ready_low_busy", 32'(busy), 32'd0);
      end
      eng_hold = 1'b0;
      @(negedge clk);
      check("grant_latency", 32'(grant), 32'(first_oh));
      check("start_with_grant", 32'(eng_start), 32'd1);
      agent_step();
      for (int c = 0; c < 200 * total && sb.size() > 0; c++) begin
         @(negedge clk);
         agent_step();
      end
      check("batch_drained", 32'(sb.size()), 32'd0);
      sb.delete();
      @(negedge clk);
      req = '0;
      @(negedge clk);
   endtask

   task automatic clear_jobs();
      for (int k = 0; k < N_REQ; k++) job_n[k] = 0;
   endtask

   task automatic single_job(input int k, input int v, input bit drop, input int hold);
      clear_jobs();
      job_n[k]      = 1;
      job_idx[k][0] = v;
      run_batch(drop, hold);
   endtask

   initial begin
      bit seen;
      reset      = 1'b1;
      req        = '0;
      idx        = '0;
      eng_hold   = 1'b0;
      drop_early = 1'b0;
      model_ptr  = 0;
      clear_jobs();
      @(negedge clk);
      do_reset(2);

      single_job(2, 20, 1'b0, 0);
      check("single_job_count", 32'(job_count), 32'd1);
      single_job(1, 0, 1'b0, 0);
      single_job(1, 1, 1'b0, 0);
      single_job(1, 30, 1'b0, 0);
      single_job(3, 31, 1'b0, 0);

      // All four requesters held: RR gives 0,1,2,3,0 from a fresh pointer.
      do_reset(2);
      clear_jobs();
      for (int k = 0; k < N_REQ; k++) begin
         job_n[k]      = 1;
         job_idx[k][0] = k + 3;
      end
      job_n[0]      = 2;
      job_idx[0][1] = 3;
      run_batch(1'b0, 0);

      clear_jobs();
      job_n[0] = 3;
      job_idx[0][0] = 7;
      job_idx[0][1] = 8;
      job_idx[0][2] = 9;
      job_n[3] = 1;
      job_idx[3][0] = 11;
      run_batch(1'b0, 0);

      single_job(1, 12, 1'b0, 5);
      single_job(3, 15, 1'b1, 0);

      // Abort a job in WAIT with reset; no done may appear for it.
      idx[1*IW +: IW] = IW'(7);
      req[1] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (eng_start) seen = 1'b1;
      end
      check("abort_launch", 32'(seen), 32'd1);
      exp_starts++;
      @(negedge clk);
      do_reset(2);
      single_job(0, 10, 1'b0, 0);
      check("post_abort_count", 32'(job_count), 32'd1);

      for (int b = 0; b < 25; b++) begin
         int tot;
         tot = 0;
         for (int k = 0; k < N_REQ; k++) begin
            job_n[k] = int'($urandom_range(0, 2));
            for (int j = 0; j < 4; j++) job_idx[k][j] = int'($urandom_range(0, 31));
            tot += job_n[k];
         end
         if (tot == 0) job_n[$urandom_range(0, N_REQ - 1)] = 1;
         run_batch(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end

      repeat (5) @(negedge clk);
      check("start_count", 32'(n_starts), 32'(exp_starts));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
